// File: rtl/icache_2way_refill.sv
// ----------------------------------------------------------------------------
// icache_2way_refill
//
// Two-way set-associative instruction cache. It has multi-word lines and one
// LRU bit per set. Lookups are combinational, so a hit is reported in the same
// cycle as the fetch. A miss starts a refill that reads the whole line from
// the memory arbiter, one word per mem_valid pulse. Lines that are not being
// refilled can still hit while the refill runs. A fence.i flush invalidates
// every line. If the flush arrives during a refill, it is deferred until that
// refill completes.
//
// Ports:
//   clk_in       clock, rising edge
//   rst_n_in     asynchronous active-low reset
//   rdy_in       global ready; low freezes all state
//   fetch_valid  fetch request present
//   fetch_addr   fetch PC (bits [1:0] ignored)
//   fetch_hit    fetch_data is valid for fetch_addr this cycle
//   fetch_data   instruction word from the hitting way
//   flush        fence.i, invalidate all lines
//   mem_req      word read request to the arbiter
//   mem_addr     word address of the read
//   mem_valid    single-cycle pulse, mem_data holds the word for mem_addr
//   mem_data     returned word
//   busy         high while a line refill is in progress
// ----------------------------------------------------------------------------
module icache_2way_refill #(
    parameter int SET_BIT  = 4,
    parameter int LINE_BIT = 2
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        rdy_in,
    input  logic        fetch_valid,
    input  logic [31:0] fetch_addr,
    output logic        fetch_hit,
    output logic [31:0] fetch_data,
    input  logic        flush,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_valid,
    input  logic [31:0] mem_data,
    output logic        busy
);

    localparam int SETS    = 1 << SET_BIT;
    localparam int WORDS   = 1 << LINE_BIT;
    localparam int TAG_BIT = 30 - SET_BIT - LINE_BIT;
    localparam int OFF_BIT = 2 + LINE_BIT;
    localparam logic [LINE_BIT-1:0] LAST_WORD = LINE_BIT'(WORDS - 1);

    typedef enum logic {
        IDLE,
        REFILL
    } state_t;

    // Address decomposition of the current fetch
    logic [TAG_BIT-1:0]  fetchTag;
    logic [SET_BIT-1:0]  fetchSet;
    logic [LINE_BIT-1:0] fetchWord;
    logic                unusedAddrBits;

    // Control state
    state_t              state_q, state_d;
    logic [LINE_BIT-1:0] cnt_q, cnt_d;
    logic [31:0]         memAddr_q, memAddr_d;
    logic                memReq_q, memReq_d;
    logic [SETS-1:0]     valid0_q, valid0_d;
    logic [SETS-1:0]     valid1_q, valid1_d;
    logic [SETS-1:0]     lru_q, lru_d;
    logic [SET_BIT-1:0]  refSet_q, refSet_d;
    logic [TAG_BIT-1:0]  refTag_q, refTag_d;
    logic                victim_q, victim_d;
    logic                flushPend_q, flushPend_d;

    // Storage arrays (not reset; valid bits guard them)
    logic [31:0]         dataMem_q [2][SETS][WORDS];
    logic [TAG_BIT-1:0]  tagMem_q  [2][SETS];

    logic hit0, hit1, anyHit, hitWay, missVictim;
    logic dataWe, tagWe;

    assign fetchTag       = fetch_addr[31:OFF_BIT+SET_BIT];
    assign fetchSet       = fetch_addr[OFF_BIT+SET_BIT-1:OFF_BIT];
    assign fetchWord      = fetch_addr[OFF_BIT-1:2];
    assign unusedAddrBits = ^fetch_addr[1:0];

    // The victim line has its valid bit cleared for the whole refill, so it
    // cannot hit until the refill completion sets the bit again.
    assign hit0   = valid0_q[fetchSet] && (tagMem_q[0][fetchSet] == fetchTag);
    assign hit1   = valid1_q[fetchSet] && (tagMem_q[1][fetchSet] == fetchTag);
    assign anyHit = hit0 || hit1;
    assign hitWay = hit1;

    assign fetch_hit  = rdy_in && fetch_valid && anyHit;
    assign fetch_data = dataMem_q[hitWay][fetchSet][fetchWord];
    assign mem_req    = memReq_q;
    assign mem_addr   = memAddr_q;
    assign busy       = (state_q == REFILL);

    // Victim choice: fill an empty way first (way0 before way1). If both
    // ways are valid, evict the way named by the LRU bit.
    assign missVictim = !valid0_q[fetchSet] ? 1'b0 :
                        !valid1_q[fetchSet] ? 1'b1 : lru_q[fetchSet];

    // Next-state logic. The order of assignments encodes priority: a hit's
    // LRU update is applied first, so refill completion and flush override it.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        memAddr_d   = memAddr_q;
        memReq_d    = memReq_q;
        valid0_d    = valid0_q;
        valid1_d    = valid1_q;
        lru_d       = lru_q;
        refSet_d    = refSet_q;
        refTag_d    = refTag_q;
        victim_d    = victim_q;
        flushPend_d = flushPend_q;
        dataWe      = 1'b0;
        tagWe       = 1'b0;

        if (rdy_in) begin
            if (fetch_hit) begin
                lru_d[fetchSet] = ~hitWay;
            end

            case (state_q)
                IDLE: begin
                    if (flush) begin
                        valid0_d = '0;
                        valid1_d = '0;
                        lru_d    = '0;
                    end else if (fetch_valid && !anyHit) begin
                        state_d   = REFILL;
                        refSet_d  = fetchSet;
                        refTag_d  = fetchTag;
                        victim_d  = missVictim;
                        cnt_d     = '0;
                        memReq_d  = 1'b1;
                        memAddr_d = {fetch_addr[31:OFF_BIT], {OFF_BIT{1'b0}}};
                        if (missVictim) begin
                            valid1_d[fetchSet] = 1'b0;
                        end else begin
                            valid0_d[fetchSet] = 1'b0;
                        end
                    end
                end

                REFILL: begin
                    // A flush during a refill is remembered. The memory
                    // transaction always runs to completion.
                    if (flush) begin
                        flushPend_d = 1'b1;
                    end
                    if (mem_valid) begin
                        dataWe    = 1'b1;
                        cnt_d     = cnt_q + 1'b1;
                        memAddr_d = memAddr_q + 32'd4;
                        if (cnt_q == LAST_WORD) begin
                            tagWe       = 1'b1;
                            memReq_d    = 1'b0;
                            state_d     = IDLE;
                            flushPend_d = 1'b0;
                            if (flushPend_q || flush) begin
                                valid0_d = '0;
                                valid1_d = '0;
                                lru_d    = '0;
                            end else begin
                                if (victim_q) begin
                                    valid1_d[refSet_q] = 1'b1;
                                end else begin
                                    valid0_d[refSet_q] = 1'b1;
                                end
                                lru_d[refSet_q] = ~victim_q;
                            end
                        end
                    end
                end

                default: state_d = IDLE;
            endcase
        end
    end

    // Control registers. Asserting reset mid-refill drops mem_req and busy
    // immediately. The half-written line stays invalid.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            memAddr_q   <= '0;
            memReq_q    <= 1'b0;
            valid0_q    <= '0;
            valid1_q    <= '0;
            lru_q       <= '0;
            refSet_q    <= '0;
            refTag_q    <= '0;
            victim_q    <= 1'b0;
            flushPend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            memAddr_q   <= memAddr_d;
            memReq_q    <= memReq_d;
            valid0_q    <= valid0_d;
            valid1_q    <= valid1_d;
            lru_q       <= lru_d;
            refSet_q    <= refSet_d;
            refTag_q    <= refTag_d;
            victim_q    <= victim_d;
            flushPend_q <= flushPend_d;
        end
    end

    // Tag and data arrays. The write enables already include rdy_in.
    always_ff @(posedge clk_in) begin
        if (dataWe) begin
            dataMem_q[victim_q][refSet_q][cnt_q] <= mem_data;
        end
        if (tagWe) begin
            tagMem_q[victim_q][refSet_q] <= refTag_q;
        end
    end

endmodule
